// File: rtl/decode_pipe_if.sv
// Fetch-side and execute-side handshake bundle for decode_pipe.
// The trap field exists only when DECODE_ILLEGAL_TRAP_EN is defined.
interface decode_pipe_if #(
  parameter int XLEN  = 16,
  parameter int DEPTH = 2
);
  logic [XLEN-1:0]          in_word;
  logic                     in_valid;
  logic                     in_ready;
  logic                     dec_valid;
  logic                     dec_ready;
  logic                     imm_en;
  logic [XLEN-1:0]          imm;
  logic                     read_a;
  logic [3:0]               arg_a;
  logic                     read_b;
  logic [3:0]               src_b;
  logic                     set_pc;
  logic                     add_pc;
  logic                     inc_pc;
  logic [1:0]               pc_src;
  logic [2:0]               cmp_b;
  logic                     alu_en;
  logic                     sh_off_imm;
  logic [3:0]               truth_table;
  logic [4:0]               alu_op;
  logic [$clog2(DEPTH):0]   fifo_count;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic                     trap;
`endif

  modport slave (
    input  in_word, in_valid, dec_ready,
    output in_ready, dec_valid, imm_en, imm, read_a, arg_a, read_b, src_b,
           set_pc, add_pc, inc_pc, pc_src, cmp_b, alu_en, sh_off_imm,
           truth_table, alu_op, fifo_count
`ifdef DECODE_ILLEGAL_TRAP_EN
    , output trap
`endif
  );

  modport master (
    output in_word, in_valid, dec_ready,
    input  in_ready, dec_valid, imm_en, imm, read_a, arg_a, read_b, src_b,
           set_pc, add_pc, inc_pc, pc_src, cmp_b, alu_en, sh_off_imm,
           truth_table, alu_op, fifo_count
`ifdef DECODE_ILLEGAL_TRAP_EN
    , input trap
`endif
  );
endinterface

// File: rtl/decode_pipe.sv
// Two-word instruction assembler + decoder feeding a DEPTH-entry control FIFO.
// Optional macro DECODE_ILLEGAL_TRAP_EN: illegal opcodes push a trap entry and stall input until flush.
module decode_pipe #(
  parameter int XLEN  = 16,
  parameter int DEPTH = 2
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  input  logic          flush,
  decode_pipe_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {S_INS = 1'b0, S_EXT = 1'b1} state_t;

  typedef struct packed {
    logic            imm_en;
    logic [XLEN-1:0] imm;
    logic            read_a;
    logic [3:0]      arg_a;
    logic            read_b;
    logic [3:0]      src_b;
    logic            set_pc;
    logic            add_pc;
    logic            inc_pc;
    logic [1:0]      pc_src;
    logic [2:0]      cmp_b;
    logic            alu_en;
    logic            sh_off_imm;
    logic [3:0]      truth_table;
    logic [4:0]      alu_op;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic            trap;
`endif
  } entry_t;

  function automatic entry_t decode(input logic [15:0] i, input logic [XLEN-1:0] ext);
    entry_t e;
    e = '0;
    case (i[15:12])
      4'h0: e.inc_pc = 1'b1;
      4'h1: begin
        e.alu_en = 1'b1; e.read_a = 1'b1; e.read_b = 1'b1; e.inc_pc = 1'b1;
        e.arg_a = i[11:8]; e.src_b = i[7:4]; e.alu_op = {1'b0, i[3:0]};
      end
      4'h2: begin
        e.alu_en = 1'b1; e.read_a = 1'b1; e.imm_en = 1'b1; e.inc_pc = 1'b1;
        e.arg_a = i[11:8]; e.imm = {{(XLEN-5){i[7]}}, i[7:3]}; e.alu_op = {2'b00, i[2:0]};
      end
      4'h3: begin
        e.alu_en = 1'b1; e.read_a = 1'b1; e.imm_en = 1'b1; e.sh_off_imm = 1'b1; e.inc_pc = 1'b1;
        e.arg_a = i[11:8]; e.imm = {{(XLEN-5){1'b0}}, i[7:3]}; e.alu_op = {2'b10, i[2:0]};
      end
      4'h4: begin
        e.alu_en = 1'b1; e.read_a = 1'b1; e.read_b = 1'b1; e.inc_pc = 1'b1;
        e.arg_a = i[11:8]; e.src_b = i[7:4]; e.truth_table = i[3:0]; e.alu_op = 5'h1F;
      end
      4'h8: begin
        e.set_pc = 1'b1; e.imm_en = 1'b1; e.pc_src = 2'b01; e.imm = ext;
      end
      4'h9: begin
        e.add_pc = 1'b1; e.imm_en = 1'b1; e.read_a = 1'b1; e.read_b = 1'b1; e.pc_src = 2'b10;
        e.cmp_b = i[11:9]; e.arg_a = {1'b0, i[8:6]}; e.src_b = {1'b0, i[5:3]}; e.imm = ext;
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      default: e.trap = 1'b1;
`else
      default: e.inc_pc = 1'b1;
`endif
    endcase
    return e;
  endfunction

  state_t          r_state;
  logic [15:0]     r_op_word;
  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_trapped;

  logic [15:0]     w_op_word;
  entry_t          w_entry;
  entry_t          w_head;
  logic            w_in_ready;
  logic            w_dec_valid;
  logic            w_xfer;
  logic            w_pop;
  logic            w_starts_ext;
  logic            w_push;

  // Handshake qualification and decode of the word (or latched opcode + extension) being accepted.
  always_comb begin
    w_op_word    = (r_state == S_EXT) ? r_op_word : bus.in_word[15:0];
    w_entry      = decode(w_op_word, bus.in_word);
    w_in_ready   = (r_count < DEPTH_C) && !flush && !r_trapped;
    w_dec_valid  = (r_count != {CW{1'b0}});
    w_xfer       = bus.in_valid && w_in_ready;
    w_pop        = w_dec_valid && bus.dec_ready && !flush;
    w_starts_ext = (r_state == S_INS) &&
                   ((w_op_word[15:12] == 4'h8) || (w_op_word[15:12] == 4'h9));
    w_push       = w_xfer && !w_starts_ext;
    w_head       = w_dec_valid ? r_mem[r_rd_ptr] : '0;
  end

  // Opcode/extension assembly FSM.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_state   <= S_INS;
      r_op_word <= 16'h0000;
    end else if (flush) begin
      r_state   <= S_INS;
      r_op_word <= 16'h0000;
    end else if (w_xfer) begin
      case (r_state)
        S_INS: begin
          if (w_starts_ext) begin
            r_state   <= S_EXT;
            r_op_word <= bus.in_word[15:0];
          end else begin
            r_state   <= S_INS;
          end
        end
        S_EXT:   r_state <= S_INS;
        default: r_state <= S_INS;
      endcase
    end else begin
      r_state <= r_state;
    end
  end

  // Decoded-entry FIFO; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Once a trap entry is queued, input stays closed until the redirect flush.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_trapped <= 1'b0;
    end else if (flush) begin
      r_trapped <= 1'b0;
    end else if (w_push && w_entry.trap) begin
      r_trapped <= 1'b1;
    end else begin
      r_trapped <= r_trapped;
    end
  end
  assign bus.trap = w_head.trap;
`else
  assign r_trapped = 1'b0;
`endif

  assign bus.in_ready    = w_in_ready;
  assign bus.dec_valid   = w_dec_valid;
  assign bus.fifo_count  = r_count;
  assign bus.imm_en      = w_head.imm_en;
  assign bus.imm         = w_head.imm;
  assign bus.read_a      = w_head.read_a;
  assign bus.arg_a       = w_head.arg_a;
  assign bus.read_b      = w_head.read_b;
  assign bus.src_b       = w_head.src_b;
  assign bus.set_pc      = w_head.set_pc;
  assign bus.add_pc      = w_head.add_pc;
  assign bus.inc_pc      = w_head.inc_pc;
  assign bus.pc_src      = w_head.pc_src;
  assign bus.cmp_b       = w_head.cmp_b;
  assign bus.alu_en      = w_head.alu_en;
  assign bus.sh_off_imm  = w_head.sh_off_imm;
  assign bus.truth_table = w_head.truth_table;
  assign bus.alu_op      = w_head.alu_op;
endmodule

// File: tb/tb_decode_pipe.sv
// Directed-vector bench for decode_pipe (XLEN=16, DEPTH=2); trap checks follow DECODE_ILLEGAL_TRAP_EN.
module tb_decode_pipe;
  logic cpu_clk;
  logic cpu_rst;
  logic flush;
  int   n_checks;
  int   n_pass;

  decode_pipe_if #(.XLEN(16), .DEPTH(2)) bus ();

  decode_pipe #(.XLEN(16), .DEPTH(2)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .flush   (flush),
    .bus     (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    bus.in_word  = w;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge cpu_clk);
      n++;
    end
    if (n >= 20) check("send_timeout_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge cpu_clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic pop();
    bus.dec_ready = 1'b1;
    @(posedge cpu_clk);
    #1 bus.dec_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cpu_rst  = 1'b0;
    flush    = 1'b0;
    bus.in_word   = 16'h0000;
    bus.in_valid  = 1'b0;
    bus.dec_ready = 1'b0;
    repeat (2) @(negedge cpu_clk);
    cpu_rst = 1'b1;
    @(negedge cpu_clk);

    check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_count",     32'(bus.fifo_count), 32'd0);
    check("rst_inc_pc",    32'(bus.inc_pc),    32'd0);
    check("rst_imm",       32'(bus.imm),       32'd0);

    // ALU reg-reg
    send(16'h1234);
    @(negedge cpu_clk);
    check("rr_dec_valid", 32'(bus.dec_valid), 32'd1);
    check("rr_alu_en",    32'(bus.alu_en),    32'd1);
    check("rr_read_ab",   32'({bus.read_a, bus.read_b}), 32'd3);
    check("rr_arg_a",     32'(bus.arg_a),     32'd2);
    check("rr_src_b",     32'(bus.src_b),     32'd3);
    check("rr_alu_op",    32'(bus.alu_op),    32'h04);
    check("rr_inc_pc",    32'(bus.inc_pc),    32'd1);
    check("rr_imm_en",    32'(bus.imm_en),    32'd0);
    pop();
    @(negedge cpu_clk);
    check("rr_popped", 32'(bus.fifo_count), 32'd0);

    // JMP long across two words
    send(16'h8000);
    @(negedge cpu_clk);
    check("jmp_no_valid_1st", 32'(bus.dec_valid), 32'd0);
    send(16'h0ABC);
    @(negedge cpu_clk);
    check("jmp_set_pc", 32'(bus.set_pc), 32'd1);
    check("jmp_pc_src", 32'(bus.pc_src), 32'd1);
    check("jmp_imm_en", 32'(bus.imm_en), 32'd1);
    check("jmp_imm",    32'(bus.imm),    32'h0ABC);
    check("jmp_inc_pc", 32'(bus.inc_pc), 32'd0);
    check("jmp_count",  32'(bus.fifo_count), 32'd1);
    pop();

    // reg-imm with negative immediate
    send(16'h20F8);
    @(negedge cpu_clk);
    check("ri_imm",    32'(bus.imm),    32'hFFFF);
    check("ri_imm_en", 32'(bus.imm_en), 32'd1);
    check("ri_arg_a",  32'(bus.arg_a),  32'd0);
    check("ri_alu_op", 32'(bus.alu_op), 32'd0);
    check("ri_alu_en", 32'(bus.alu_en), 32'd1);
    pop();

    // shift-imm: zero-extended
    send(16'h35FA);
    @(negedge cpu_clk);
    check("sh_imm",    32'(bus.imm),        32'h001F);
    check("sh_off",    32'(bus.sh_off_imm), 32'd1);
    check("sh_arg_a",  32'(bus.arg_a),      32'd5);
    check("sh_alu_op", 32'(bus.alu_op),     32'h12);
    pop();

    // logic op
    send(16'h4A5C);
    @(negedge cpu_clk);
    check("lg_arg_a", 32'(bus.arg_a),       32'hA);
    check("lg_src_b", 32'(bus.src_b),       32'h5);
    check("lg_tt",    32'(bus.truth_table), 32'hC);
    check("lg_alu_op",32'(bus.alu_op),      32'h1F);
    pop();

    // branch
    send(16'h9B5F);
    send(16'h1234);
    @(negedge cpu_clk);
    check("br_add_pc", 32'(bus.add_pc), 32'd1);
    check("br_pc_src", 32'(bus.pc_src), 32'd2);
    check("br_cmp_b",  32'(bus.cmp_b),  32'd5);
    check("br_arg_a",  32'(bus.arg_a),  32'd5);
    check("br_src_b",  32'(bus.src_b),  32'd3);
    check("br_imm",    32'(bus.imm),    32'h1234);
    check("br_read_ab",32'({bus.read_a, bus.read_b}), 32'd3);
    pop();

    // backpressure, ordering, simultaneous push/pop
    send(16'h1100);
    send(16'h1200);
    @(negedge cpu_clk);
    check("bp_in_ready_full", 32'(bus.in_ready),   32'd0);
    check("bp_count_full",    32'(bus.fifo_count), 32'd2);
    check("bp_head1",         32'(bus.arg_a),      32'd1);
    bus.in_word  = 16'h1300;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge cpu_clk);
    check("bp_held", 32'(bus.fifo_count), 32'd2);
    bus.dec_ready = 1'b1;
    @(posedge cpu_clk);
    #1 bus.dec_ready = 1'b0;
    @(negedge cpu_clk);
    check("bp_ready_after_pop", 32'(bus.in_ready),   32'd1);
    check("bp_count_after_pop", 32'(bus.fifo_count), 32'd1);
    check("bp_head2",           32'(bus.arg_a),      32'd2);
    @(posedge cpu_clk);
    #1 bus.in_valid = 1'b0;
    @(negedge cpu_clk);
    check("bp_third_in", 32'(bus.fifo_count), 32'd2);
    pop();
    @(negedge cpu_clk);
    check("bp_head3", 32'(bus.arg_a), 32'd3);
    bus.in_word   = 16'h1400;
    bus.in_valid  = 1'b1;
    bus.dec_ready = 1'b1;
    @(posedge cpu_clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.dec_ready = 1'b0;
    @(negedge cpu_clk);
    check("pp_count", 32'(bus.fifo_count), 32'd1);
    check("pp_head4", 32'(bus.arg_a),      32'd4);
    pop();
    @(negedge cpu_clk);
    check("pp_empty", 32'(bus.dec_valid), 32'd0);

    // flush in S_EXT drops the pending branch
    send(16'h9000);
    @(negedge cpu_clk);
    flush = 1'b1;
    #1 check("fl_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge cpu_clk);
    #1 flush = 1'b0;
    send(16'h0000);
    @(negedge cpu_clk);
    check("fl_count",  32'(bus.fifo_count), 32'd1);
    check("fl_inc_pc", 32'(bus.inc_pc),     32'd1);
    check("fl_add_pc", 32'(bus.add_pc),     32'd0);
    send(16'h0000);
    @(negedge cpu_clk);
    flush = 1'b1;
    bus.dec_ready = 1'b1;
    @(posedge cpu_clk);
    #1;
    flush = 1'b0;
    bus.dec_ready = 1'b0;
    @(negedge cpu_clk);
    check("fl_full_cleared", 32'(bus.fifo_count), 32'd0);
    check("fl_dec_valid",    32'(bus.dec_valid),  32'd0);

    // illegal opcode
    send(16'hF000);
    @(negedge cpu_clk);
    check("ill_count", 32'(bus.fifo_count), 32'd1);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("ill_trap",     32'(bus.trap),     32'd1);
    check("ill_inc_pc",   32'(bus.inc_pc),   32'd0);
    check("ill_in_ready", 32'(bus.in_ready), 32'd0);
    pop();
    @(negedge cpu_clk);
    check("ill_stuck", 32'(bus.in_ready), 32'd0);
    flush = 1'b1;
    @(posedge cpu_clk);
    #1 flush = 1'b0;
    @(negedge cpu_clk);
    check("ill_reopen", 32'(bus.in_ready), 32'd1);
    check("ill_trap_clr", 32'(bus.trap), 32'd0);
`else
    check("ill_inc_pc",   32'(bus.inc_pc),   32'd1);
    check("ill_alu_en",   32'(bus.alu_en),   32'd0);
    check("ill_in_ready", 32'(bus.in_ready), 32'd1);
    pop();
`endif

    // async reset mid-instruction
    send(16'h8000);
    #2 cpu_rst = 1'b0;
    #2 cpu_rst = 1'b1;
    send(16'h0000);
    @(negedge cpu_clk);
    check("rst_mid_inc_pc", 32'(bus.inc_pc), 32'd1);
    check("rst_mid_set_pc", 32'(bus.set_pc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised, buffered successor to the single-cycle instruction decoder.
- Accepts a stream of XLEN-wide words over a valid/ready handshake and assembles two-word instructions (opcode word plus extension word) with an internal FSM.
- Decodes each instruction into a control bundle and queues it in a DEPTH-entry FIFO, which the execute stage drains over its own valid/ready handshake.
- Sits between fetch and execute. A flush input discards in-flight decode state on PC redirect.

Parameters:
- XLEN, 16, word/extension/immediate width; legal values are 16 or greater; instruction opcode word is in_word[15:0].
- DEPTH, 2, decoded-entry FIFO depth; power of two, 2 or greater.

Ports:
- cpu_clk  in  1  clock, rising edge.
- cpu_rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of FSM state and FIFO.
- in_word  in  XLEN  instruction or extension word.
- in_valid  in  1  in_word valid.
- in_ready  out  1  decoder can accept in_word.
- dec_valid  out  1  FIFO head valid.
- dec_ready  in  1  consumer pops head.
- imm_en  out  1  immediate operand used.
- imm  out  XLEN  immediate/extension value.
- read_a  out  1  read register A.
- arg_a  out  4  register A index.
- read_b  out  1  read register B.
- src_b  out  4  register B index.
- set_pc  out  1  absolute PC load.
- add_pc  out  1  PC-relative add.
- inc_pc  out  1  sequential PC increment.
- pc_src  out  2  PC source select.
- cmp_b  out  3  branch condition code.
- alu_en  out  1  ALU operation.
- sh_off_imm  out  1  shift offset from immediate.
- truth_table  out  4  logic-unit truth table.
- alu_op  out  5  ALU operation code.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:

Reset (cpu_rst=0, asynchronous):
- FSM goes to S_INS; FIFO is emptied.
- All outputs are 0, except in_ready, which is 1 once reset is released.

Handshakes:
- Input transfer when in_valid && in_ready; output pop when dec_valid && dec_ready.
- in_ready = (fifo_count < DEPTH) && !flush. A full FIFO blocks input even if a pop occurs in the same cycle.
- dec_valid = (fifo_count != 0).
- All bundle outputs are zero when dec_valid=0; otherwise they present the head entry.

FSM:
- S_INS: accepted word with op = in_word[15:12].
  - op 8 or 9: latch the word and go to S_EXT; nothing is pushed.
  - Any other op: push the decoded entry.
- S_EXT: the accepted word is the extension. Push the entry built from the latched opcode plus the extension; go to S_INS.

Latency: an entry is visible (dec_valid=1) in the cycle after the transfer that completes it.

Decode (i = opcode word); unlisted fields are 0:
- op 0, NOP: inc_pc=1.
- op 1, ALU reg-reg: alu_en, read_a, read_b, inc_pc; arg_a=i[11:8], src_b=i[7:4], alu_op={0,i[3:0]}.
- op 2, ALU reg-imm: alu_en, read_a, imm_en, inc_pc; arg_a=i[11:8]; imm=sign-extend(i[7:3]) to XLEN; alu_op={00,i[2:0]}.
- op 3, shift-imm: alu_en, read_a, imm_en, sh_off_imm, inc_pc; arg_a=i[11:8]; imm=zero-extend(i[7:3]); alu_op={10,i[2:0]}.
- op 4, logic: alu_en, read_a, read_b, inc_pc; arg_a=i[11:8], src_b=i[7:4], truth_table=i[3:0], alu_op=5'h1F.
- op 8, JMP long: set_pc, imm_en; pc_src=01; imm=ext.
- op 9, branch: add_pc, imm_en, read_a, read_b; pc_src=10; cmp_b=i[11:9]; arg_a={0,i[8:6]}; src_b={0,i[5:3]}; imm=ext.
- ops 5–7 and A–F: illegal; see Optional Feature.

Boundaries:
- flush=1: FSM returns to S_INS, the latched opcode is dropped, fifo_count=0, and no push or pop occurs that cycle. Flush overrides every simultaneous event.
- Push and pop in the same cycle: count is unchanged; pointers wrap modulo DEPTH.
- Reset mid-instruction (in S_EXT) behaves as reset.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port trap (1 bit, reset 0).
  - An illegal opcode pushes an entry with trap=1 and all other fields 0.
  - After that push, in_ready stays 0 until flush.
- Undefined: an illegal opcode decodes exactly as NOP (inc_pc=1); there is no trap port.

Test Plan:
- Reset, then release -> dec_valid=0, in_ready=1, fifo_count=0, all bundle outputs 0.
- Word 0x1234, dec_ready=1 -> next cycle: dec_valid=1, alu_en=1, read_a=1, read_b=1, arg_a=2, src_b=3, alu_op=5'h04, inc_pc=1.
- Word 0x8000, then ext 0x0ABC -> no dec_valid after the first word; after the ext: set_pc=1, pc_src=01, imm_en=1, imm=0x0ABC; fifo_count=1.
- Word 0x20F8 (imm field 11111) -> imm=0xFFFF, imm_en=1, arg_a=0, alu_op=0.
- Backpressure: dec_ready=0, DEPTH=2, send three NOPs -> in_ready=0 after two; the third is held. Pop once -> in_ready=1, the third is accepted, order is preserved.
- Word 0x9000, then flush in S_EXT; next word 0x0000 -> single NOP entry (inc_pc=1), no branch entry. Word 0xF000: with the macro, trap=1 and in_ready=0 until flush; without it, NOP.
